// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared widths, NOP encoding and loader state type
package program_loader_pkg;

    localparam int CPU_PC_WIDTH          = 8;
    localparam int CPU_INSTRUCTION_WIDTH = 16;

    localparam logic [CPU_INSTRUCTION_WIDTH-1:0] NOP_ENCODING = '0;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } loader_state_e;

endpackage

// File: rtl/program_ram.sv
// rtl/program_ram.sv - single-write/single-read synchronous RAM with registered read
module program_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] read_data
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] read_data_d;
    logic [DATA_WIDTH-1:0] read_data_q;

    // A disabled read returns zero so the fetch path sees NOPs while loading.
    always_comb begin
        read_data_d = '0;
        if (read_en) begin
            read_data_d = mem[read_addr];
        end
    end

    always_ff @(posedge clock) begin
        if (write_en) begin
            mem[write_addr] <= write_data;
        end
        read_data_q <= read_data_d;
    end

    assign read_data = read_data_q;

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream program loader and instruction memory front end
module program_loader
    import program_loader_pkg::*;
#(
    parameter int PC_WIDTH          = CPU_PC_WIDTH,
    parameter int INSTRUCTION_WIDTH = CPU_INSTRUCTION_WIDTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [PC_WIDTH-1:0]          pc,
    output logic [INSTRUCTION_WIDTH-1:0] instruction,
    input  logic                         loadValid,
    output logic                         loadReady,
    input  logic [7:0]                   loadByte,
    input  logic                         loadLast,
    output logic                         cpuReset,
    output logic                         loadDone,
    output logic                         overflow,
    output logic [PC_WIDTH:0]            wordCount
);

    localparam int BYTES = INSTRUCTION_WIDTH / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [CNT_W-1:0]    LAST_LANE = CNT_W'(BYTES - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE   = 1;
    localparam logic [PC_WIDTH-1:0] ADDR_ONE  = 1;
    localparam logic [PC_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [PC_WIDTH:0]   COUNT_ONE = 1;

    loader_state_e                state_q, state_d;
    logic [CNT_W-1:0]             byte_cnt_q, byte_cnt_d;
    logic [INSTRUCTION_WIDTH-1:0] word_q, word_d;
    logic [PC_WIDTH-1:0]          write_addr_q, write_addr_d;
    logic [PC_WIDTH:0]            word_count_q, word_count_d;
    logic                         overflow_q, overflow_d;
    logic                         done_q, done_d;
    logic                         ready_q, ready_d;
    logic                         cpu_reset_q, cpu_reset_d;

    logic                         accept;
    logic                         word_end;
    logic                         at_top;
    logic                         write_en;
    logic [CNT_W-1:0]             byte_lane;
    logic [INSTRUCTION_WIDTH-1:0] assembled;
    logic                         read_en;

    always_comb begin
        accept    = loadValid && ready_q;
        word_end  = (byte_cnt_q == LAST_LANE) || loadLast;
        at_top    = (write_addr_q == LAST_ADDR);
        write_en  = accept && word_end && !reset;
        // Byte k of a word lands k lanes below the MSB lane.
        byte_lane = LAST_LANE - byte_cnt_q;
        assembled = word_q | (INSTRUCTION_WIDTH'(loadByte) << {byte_lane, 3'b000});
        read_en   = (state_q == RUN) && !reset;

        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        word_d       = word_q;
        write_addr_d = write_addr_q;
        word_count_d = word_count_q;
        overflow_d   = overflow_q;
        done_d       = done_q;

        if (accept) begin
            if (word_end) begin
                byte_cnt_d   = '0;
                word_d       = '0;
                word_count_d = word_count_q + COUNT_ONE;
                if (!at_top) begin
                    write_addr_d = write_addr_q + ADDR_ONE;
                end
                if (loadLast || at_top) begin
                    state_d    = RUN;
                    done_d     = 1'b1;
                    overflow_d = !loadLast;
                end
            end else begin
                byte_cnt_d = byte_cnt_q + CNT_ONE;
                word_d     = assembled;
            end
        end

        ready_d     = (state_d == LOAD);
        cpu_reset_d = (state_q != RUN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= LOAD;
            byte_cnt_q   <= '0;
            word_q       <= '0;
            write_addr_q <= '0;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
            ready_q      <= 1'b0;
            cpu_reset_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            word_q       <= word_d;
            write_addr_q <= write_addr_d;
            word_count_q <= word_count_d;
            overflow_q   <= overflow_d;
            done_q       <= done_d;
            ready_q      <= ready_d;
            cpu_reset_q  <= cpu_reset_d;
        end
    end

    program_ram #(
        .ADDR_WIDTH (PC_WIDTH),
        .DATA_WIDTH (INSTRUCTION_WIDTH)
    ) u_program_ram (
        .clock      (clock),
        .write_en   (write_en),
        .write_addr (write_addr_q),
        .write_data (assembled),
        .read_en    (read_en),
        .read_addr  (pc),
        .read_data  (instruction)
    );

    assign loadReady = ready_q;
    assign cpuReset  = cpu_reset_q;
    assign loadDone  = done_q;
    assign overflow  = overflow_q;
    assign wordCount = word_count_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

    logic        clock = 1'b0;
    logic        reset;

    logic [7:0]  pc;
    logic [15:0] instruction;
    logic        load_valid;
    logic        load_ready;
    logic [7:0]  load_byte;
    logic        load_last;
    logic        cpu_reset;
    logic        load_done;
    logic        overflow;
    logic [8:0]  word_count;

    logic [1:0]  pc2;
    logic [15:0] instruction2;
    logic        load_valid2;
    logic        load_ready2;
    logic [7:0]  load_byte2;
    logic        load_last2;
    logic        cpu_reset2;
    logic        load_done2;
    logic        overflow2;
    logic [2:0]  word_count2;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    program_loader #(.PC_WIDTH(8), .INSTRUCTION_WIDTH(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .pc          (pc),
        .instruction (instruction),
        .loadValid   (load_valid),
        .loadReady   (load_ready),
        .loadByte    (load_byte),
        .loadLast    (load_last),
        .cpuReset    (cpu_reset),
        .loadDone    (load_done),
        .overflow    (overflow),
        .wordCount   (word_count)
    );

    program_loader #(.PC_WIDTH(2), .INSTRUCTION_WIDTH(16)) dut_small (
        .clock       (clock),
        .reset       (reset),
        .pc          (pc2),
        .instruction (instruction2),
        .loadValid   (load_valid2),
        .loadReady   (load_ready2),
        .loadByte    (load_byte2),
        .loadLast    (load_last2),
        .cpuReset    (cpu_reset2),
        .loadDone    (load_done2),
        .overflow    (overflow2),
        .wordCount   (word_count2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        load_valid = 1'b1;
        load_byte  = b;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic restart();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        pc = 8'd0;  load_valid = 1'b0;  load_byte = 8'd0;  load_last = 1'b0;
        pc2 = 2'd0; load_valid2 = 1'b0; load_byte2 = 8'd0; load_last2 = 1'b0;

        tick();
        chk("rst_instruction", 32'(instruction), 32'h0);
        chk("rst_cpu_reset",   32'(cpu_reset),   32'h1);
        chk("rst_load_done",   32'(load_done),   32'h0);
        chk("rst_overflow",    32'(overflow),    32'h0);
        chk("rst_word_count",  32'(word_count),  32'h0);
        chk("rst_load_ready",  32'(load_ready),  32'h0);
        reset = 1'b0;
        tick();
        chk("post_rst_ready",     32'(load_ready),  32'h1);
        chk("post_rst_cpu_reset", 32'(cpu_reset),   32'h1);

        // Three-word load, with fetch attempts during LOAD
        pc = 8'd0;
        send(8'h12, 1'b0);
        send(8'h34, 1'b0);
        send(8'h56, 1'b0);
        send(8'h78, 1'b0);
        send(8'h9A, 1'b0);
        chk("load_fetch_nop",  32'(instruction), 32'h0);
        chk("load_cpu_reset",  32'(cpu_reset),   32'h1);
        chk("load_wc_mid",     32'(word_count),  32'h2);
        send(8'hBC, 1'b1);
        chk("last_done",       32'(load_done),   32'h1);
        chk("last_ready",      32'(load_ready),  32'h0);
        chk("last_wc",         32'(word_count),  32'h3);
        chk("last_cpu_reset",  32'(cpu_reset),   32'h1);
        tick();
        chk("run_cpu_reset",   32'(cpu_reset),   32'h0);
        chk("fetch_0",         32'(instruction), 32'h1234);
        pc = 8'd1;
        tick();
        chk("fetch_1",         32'(instruction), 32'h5678);
        pc = 8'd2;
        tick();
        chk("fetch_2",         32'(instruction), 32'h9ABC);

        // Odd-length load
        reset = 1'b1;
        tick();
        chk("rerst_wc",        32'(word_count),  32'h0);
        chk("rerst_done",      32'(load_done),   32'h0);
        chk("rerst_cpu_reset", 32'(cpu_reset),   32'h1);
        chk("rerst_fetch",     32'(instruction), 32'h0);
        reset = 1'b0;
        tick();
        send(8'hAB, 1'b0);
        send(8'hCD, 1'b0);
        send(8'hEF, 1'b1);
        chk("odd_wc",          32'(word_count),  32'h2);
        chk("odd_done",        32'(load_done),   32'h1);
        chk("odd_overflow",    32'(overflow),    32'h0);
        pc = 8'd1;
        tick();
        chk("odd_fetch_1",     32'(instruction), 32'hEF00);
        pc = 8'd0;
        tick();
        chk("odd_fetch_0",     32'(instruction), 32'hABCD);

        // Gapped stream
        restart();
        for (int b = 0; b < 4; b++) begin
            send(8'(b), b == 3);
            if (b != 3) begin
                tick();
                chk("gap_ready", 32'(load_ready), 32'h1);
            end
        end
        chk("gap_wc",          32'(word_count),  32'h2);
        pc = 8'd0;
        tick();
        chk("gap_fetch_0",     32'(instruction), 32'h0001);
        pc = 8'd1;
        tick();
        chk("gap_fetch_1",     32'(instruction), 32'h0203);

        // Reset in the middle of a load
        restart();
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        reset = 1'b1;
        tick();
        chk("mid_rst_wc",      32'(word_count),  32'h0);
        chk("mid_rst_ready",   32'(load_ready),  32'h0);
        reset = 1'b0;
        tick();
        chk("mid_ready",       32'(load_ready),  32'h1);
        chk("mid_cpu_reset",   32'(cpu_reset),   32'h1);
        send(8'h44, 1'b0);
        send(8'h55, 1'b1);
        chk("mid_wc",          32'(word_count),  32'h1);
        chk("mid_cpu_reset_n", 32'(cpu_reset),   32'h1);
        pc = 8'd0;
        tick();
        chk("mid_cpu_run",     32'(cpu_reset),   32'h0);
        chk("mid_fetch_0",     32'(instruction), 32'h4455);
        pc = 8'd1;
        tick();
        chk("mid_mem_kept",    32'(instruction), 32'h0203);

        // Overflow on the four-word instance: 10 bytes, no loadLast
        chk("ovf_ready_start", 32'(load_ready2), 32'h1);
        load_valid2 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            load_byte2 = 8'(k);
            pc2 = (k == 9) ? 2'd3 : 2'd0;
            tick();
            if (k == 7) begin
                chk("ovf_pre_flag",  32'(overflow2),   32'h0);
                chk("ovf_pre_wc",    32'(word_count2), 32'h3);
            end
            if (k == 8) begin
                chk("ovf_flag",      32'(overflow2),   32'h1);
                chk("ovf_done",      32'(load_done2),  32'h1);
                chk("ovf_ready",     32'(load_ready2), 32'h0);
                chk("ovf_wc",        32'(word_count2), 32'h4);
                chk("ovf_cpu_reset", 32'(cpu_reset2),  32'h1);
            end
            if (k == 9) begin
                chk("ovf_fetch_3",   32'(instruction2), 32'h0708);
                chk("ovf_cpu_run",   32'(cpu_reset2),   32'h0);
                chk("ovf_ign_ready", 32'(load_ready2),  32'h0);
            end
            if (k == 10) begin
                chk("ovf_fetch_0",   32'(instruction2), 32'h0102);
                chk("ovf_ign_wc",    32'(word_count2),  32'h4);
            end
        end
        load_valid2 = 1'b0;
        pc2 = 2'd3;
        tick();
        chk("ovf_mem3_kept",   32'(instruction2), 32'h0708);
        pc2 = 2'd2;
        tick();
        chk("ovf_fetch_2",     32'(instruction2), 32'h0506);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
